// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store memory access unit
// Accepts one request at a time, issues a word-aligned byte-enabled access and reports completion.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        ld_valid,
    output logic [31:0] ld_mdr,
    output logic [31:0] ld_addr,
    output logic [2:0]  ld_type,
    output logic        st_done,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R} state_t;

    state_t      state;
    logic        lat_we;
    logic [2:0]  lat_type;
    logic [31:0] lat_addr;

    logic        req_misalign;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;

    // Lane selection and store-data replication decoded straight from the request.
    always_comb begin
        req_misalign = 1'b0;
        be_calc      = 4'b0000;
        wdata_calc   = 32'h0;
        case (req_type)
            3'b000, 3'b011: begin
                be_calc    = 4'b0001 << req_addr[1:0];
                wdata_calc = {4{req_wdata[7:0]}};
            end
            3'b001, 3'b100: begin
                be_calc      = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc   = {2{req_wdata[15:0]}};
                req_misalign = req_addr[0];
            end
            3'b010: begin
                be_calc      = 4'b1111;
                wdata_calc   = req_wdata;
                req_misalign = |req_addr[1:0];
            end
            default: req_misalign = 1'b1;
        endcase
        if (!req_we) begin
            wdata_calc = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
            ld_valid  <= 1'b0;
            ld_mdr    <= 32'h0;
            ld_addr   <= 32'h0;
            ld_type   <= 3'b000;
            st_done   <= 1'b0;
            misalign  <= 1'b0;
            lat_we    <= 1'b0;
            lat_type  <= 3'b000;
            lat_addr  <= 32'h0;
        end else begin
            ld_valid <= 1'b0;
            st_done  <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        lat_we   <= req_we;
                        lat_type <= req_type;
                        lat_addr <= req_addr;
                        if (req_misalign) begin
                            misalign <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            req_ready <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= be_calc;
                            mem_wdata <= wdata_calc;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= 32'h0;
                        if (lat_we) begin
                            state     <= IDLE;
                            st_done   <= 1'b1;
                            req_ready <= 1'b1;
                        end else begin
                            state <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    // Read data is captured raw; byte extraction happens downstream.
                    if (mem_rvalid) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        ld_valid  <= 1'b1;
                        ld_mdr    <= mem_rdata;
                        ld_addr   <= lat_addr;
                        ld_type   <= lat_type;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ld_valid;
    logic [31:0] ld_mdr;
    logic [31:0] ld_addr;
    logic [2:0]  ld_type;
    logic        st_done;
    logic        misalign;

    int checks;
    int failures;
    int txn_cnt;
    int txn_base;
    logic mem_req_q;

    mem_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ld_valid   (ld_valid),
        .ld_mdr     (ld_mdr),
        .ld_addr    (ld_addr),
        .ld_type    (ld_type),
        .st_done    (st_done),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count memory transactions as rising edges of mem_req.
    initial begin
        txn_cnt   = 0;
        mem_req_q = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !mem_req_q) txn_cnt++;
            mem_req_q = mem_req;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = typ;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_type   = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        step();
        step();
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_ld_valid", {31'h0, ld_valid}, 32'h0);
        chk("rst_ld_mdr", ld_mdr, 32'h0);
        chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

        // LB at 0x1003, immediate grant, data next cycle
        set_req(1'b0, 3'b000, 32'h0000_1003, 32'h0);
        step();
        req_valid = 1'b0;
        chk("lb_mem_req", {31'h0, mem_req}, 32'h1);
        chk("lb_mem_addr", mem_addr, 32'h0000_1000);
        chk("lb_mem_be", {28'h0, mem_be}, 32'h8);
        chk("lb_mem_we", {31'h0, mem_we}, 32'h0);
        chk("lb_mem_wdata", mem_wdata, 32'h0);
        chk("lb_ready_busy", {31'h0, req_ready}, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80FF_1234;
        chk("lb_req_dropped", {31'h0, mem_req}, 32'h0);
        chk("lb_no_early_valid", {31'h0, ld_valid}, 32'h0);
        step();
        mem_rvalid = 1'b0;
        chk("lb_ld_valid", {31'h0, ld_valid}, 32'h1);
        chk("lb_ld_mdr", ld_mdr, 32'h80FF_1234);
        chk("lb_ld_addr", ld_addr, 32'h0000_1003);
        chk("lb_ld_type", {29'h0, ld_type}, 32'h0);
        step();
        chk("lb_valid_pulse", {31'h0, ld_valid}, 32'h0);

        // SH at 0x2002, grant delayed two cycles
        set_req(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("sh_mem_req", {31'h0, mem_req}, 32'h1);
            chk("sh_mem_we", {31'h0, mem_we}, 32'h1);
            chk("sh_mem_addr", mem_addr, 32'h0000_2000);
            chk("sh_mem_be", {28'h0, mem_be}, 32'hC);
            chk("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
            chk("sh_no_done", {31'h0, st_done}, 32'h0);
            if (i == 2) mem_gnt = 1'b1;
            step();
        end
        mem_gnt = 1'b0;
        chk("sh_st_done", {31'h0, st_done}, 32'h1);
        chk("sh_req_off", {31'h0, mem_req}, 32'h0);
        chk("sh_be_off", {28'h0, mem_be}, 32'h0);
        step();
        chk("sh_done_pulse", {31'h0, st_done}, 32'h0);

        // Misaligned LW and LH, then LBU at the same address is legal
        set_req(1'b0, 3'b010, 32'h0000_3001, 32'h0);
        step();
        req_valid = 1'b0;
        chk("lw_misalign", {31'h0, misalign}, 32'h1);
        chk("lw_no_req", {31'h0, mem_req}, 32'h0);
        chk("lw_ready", {31'h0, req_ready}, 32'h1);
        step();
        chk("lw_misalign_pulse", {31'h0, misalign}, 32'h0);
        chk("lw_still_no_req", {31'h0, mem_req}, 32'h0);
        set_req(1'b0, 3'b001, 32'h0000_3001, 32'h0);
        step();
        req_valid = 1'b0;
        chk("lh_misalign", {31'h0, misalign}, 32'h1);
        chk("lh_no_req", {31'h0, mem_req}, 32'h0);
        set_req(1'b0, 3'b011, 32'h0000_3001, 32'h0);
        step();
        req_valid = 1'b0;
        chk("lbu_no_misalign", {31'h0, misalign}, 32'h0);
        chk("lbu_mem_req", {31'h0, mem_req}, 32'h1);
        chk("lbu_mem_be", {28'h0, mem_be}, 32'h2);
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1122_3344;
        step();
        mem_rvalid = 1'b0;
        chk("lbu_ld_valid", {31'h0, ld_valid}, 32'h1);
        chk("lbu_ld_mdr", ld_mdr, 32'h1122_3344);
        chk("lbu_ld_addr", ld_addr, 32'h0000_3001);
        chk("lbu_ld_type", {29'h0, ld_type}, 32'h3);
        step();

        // Stray rvalid in IDLE and in ISSUE
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        chk("idle_rvalid_no_valid", {31'h0, ld_valid}, 32'h0);
        chk("idle_rvalid_mdr", ld_mdr, 32'h1122_3344);
        set_req(1'b0, 3'b010, 32'h0000_4000, 32'h0);
        step();
        req_valid  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        chk("issue_rvalid_no_valid", {31'h0, ld_valid}, 32'h0);
        chk("issue_rvalid_mdr", ld_mdr, 32'h1122_3344);
        chk("issue_still_req", {31'h0, mem_req}, 32'h1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;

        // Reset while waiting for read data, then a late rvalid
        rst = 1'b1;
        step();
        chk("wr_rst_ready", {31'h0, req_ready}, 32'h0);
        chk("wr_rst_mdr", ld_mdr, 32'h0);
        chk("wr_rst_addr", ld_addr, 32'h0);
        chk("wr_rst_req", {31'h0, mem_req}, 32'h0);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        step();
        mem_rvalid = 1'b0;
        chk("wr_late_no_valid", {31'h0, ld_valid}, 32'h0);
        chk("wr_late_mdr", ld_mdr, 32'h0);
        chk("wr_ready_after", {31'h0, req_ready}, 32'h1);
        step();
        chk("wr_late_no_valid2", {31'h0, ld_valid}, 32'h0);

        // Back-to-back SB then LW with req_valid held
        txn_base = txn_cnt;
        set_req(1'b1, 3'b000, 32'h0000_0010, 32'h0000_00A5);
        step();
        set_req(1'b0, 3'b010, 32'h0000_0014, 32'h0);
        chk("b2b_sb_req", {31'h0, mem_req}, 32'h1);
        chk("b2b_sb_be", {28'h0, mem_be}, 32'h1);
        chk("b2b_sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("b2b_sb_busy", {31'h0, req_ready}, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("b2b_st_done", {31'h0, st_done}, 32'h1);
        chk("b2b_ready", {31'h0, req_ready}, 32'h1);
        chk("b2b_req_gap", {31'h0, mem_req}, 32'h0);
        step();
        req_valid = 1'b0;
        chk("b2b_lw_req", {31'h0, mem_req}, 32'h1);
        chk("b2b_lw_addr", mem_addr, 32'h0000_0014);
        chk("b2b_lw_be", {28'h0, mem_be}, 32'hF);
        chk("b2b_lw_we", {31'h0, mem_we}, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0102_0304;
        step();
        mem_rvalid = 1'b0;
        chk("b2b_ld_valid", {31'h0, ld_valid}, 32'h1);
        chk("b2b_ld_addr", ld_addr, 32'h0000_0014);
        chk("b2b_ld_mdr", ld_mdr, 32'h0102_0304);
        step();
        step();
        chk("b2b_txn_count", txn_cnt - txn_base, 32'd2);
        chk("b2b_idle_req", {31'h0, mem_req}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
